axis_s_arb: RTL and testbench

AXIS_S_ARB -- requirements
Module: axis_s_arb

---
 rtl/axis_s_arb.sv | 123 ++++++++++++
 tb/tb_axis_s_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_s_arb.sv
// Two-requester AXI-Stream arbiter feeding a single registered backend beat.
// Grants are held for a whole packet; round-robin or fixed priority to s0.
module axis_s_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic                    prio_mode,

  input  logic                    s0_tvalid,
  input  logic [DATA_WIDTH-1:0]   s0_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
  input  logic                    s0_tlast,
  input  logic [USER_WIDTH-1:0]   s0_tuser,
  output logic                    s0_tready,

  input  logic                    s1_tvalid,
  input  logic [DATA_WIDTH-1:0]   s1_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
  input  logic                    s1_tlast,
  input  logic [USER_WIDTH-1:0]   s1_tuser,
  output logic                    s1_tready,

  output logic [DATA_WIDTH-1:0]   bk_data,
  output logic [DATA_WIDTH/8-1:0] bk_tstrb,
  output logic [DATA_WIDTH/8-1:0] bk_tkeep,
  output logic [USER_WIDTH-1:0]   bk_user,
  output logic                    bk_tlast,
  output logic                    bk_valid,
  input  logic                    bk_ready,

  output logic [1:0]              arb_grant
);

  // State codes double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  state_e state;
  logic   rr_ptr;
  logic   out_free;
  logic   acc0;
  logic   acc1;

  // The backend slot can take a new beat when empty or being drained this cycle.
  assign out_free  = !bk_valid || bk_ready;
  assign s0_tready = (state == GRANT0) && out_free;
  assign s1_tready = (state == GRANT1) && out_free;
  assign acc0      = s0_tvalid && s0_tready;
  assign acc1      = s1_tvalid && s1_tready;
  assign arb_grant = state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (prio_mode) begin
            if (s0_tvalid)      state <= GRANT0;
            else if (s1_tvalid) state <= GRANT1;
          end else begin
            if (s0_tvalid && s1_tvalid) state <= rr_ptr ? GRANT1 : GRANT0;
            else if (s0_tvalid)         state <= GRANT0;
            else if (s1_tvalid)         state <= GRANT1;
          end
        end
        GRANT0: begin
          if (acc0 && s0_tlast) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
          end
        end
        GRANT1: begin
          if (acc1 && s1_tlast) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the backend payload registers are reset as well as bk_valid, so a
  // reset leaves no stale beat visible on the outputs.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      bk_valid <= 1'b0;
      bk_data  <= '0;
      bk_tstrb <= '0;
      bk_tkeep <= '0;
      bk_user  <= '0;
      bk_tlast <= 1'b0;
    end else if (acc0) begin
      bk_valid <= 1'b1;
      bk_data  <= s0_tdata;
      bk_tstrb <= s0_tstrb;
      bk_tkeep <= s0_tkeep;
      bk_user  <= s0_tuser;
      bk_tlast <= s0_tlast;
    end else if (acc1) begin
      bk_valid <= 1'b1;
      bk_data  <= s1_tdata;
      bk_tstrb <= s1_tstrb;
      bk_tkeep <= s1_tkeep;
      bk_user  <= s1_tuser;
      bk_tlast <= s1_tlast;
    end else if (bk_ready) begin
      bk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_s_arb.sv
// Scoreboard bench for axis_s_arb: expected beats are queued in arbitration
// order and popped as the backend consumes them.
module tb_axis_s_arb;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          axi_areset;
  logic          prio_mode;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic [DW-1:0] s0_tdata;
  logic [KW-1:0] s0_tstrb, s0_tkeep;
  logic [UW-1:0] s0_tuser;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic [DW-1:0] s1_tdata;
  logic [KW-1:0] s1_tstrb, s1_tkeep;
  logic [UW-1:0] s1_tuser;
  logic [DW-1:0] bk_data;
  logic [KW-1:0] bk_tstrb, bk_tkeep;
  logic [UW-1:0] bk_user;
  logic          bk_tlast, bk_valid, bk_ready;
  logic [1:0]    arb_grant;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  beat_t      sb[$];
  logic [1:0] gpat[$];
  logic       vpat[$];
  logic       rpat[$];
  logic       stress_done;

  axis_s_arb #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .axi_aclk  (clk),
    .axi_areset(axi_areset),
    .prio_mode (prio_mode),
    .s0_tvalid (s0_tvalid),
    .s0_tdata  (s0_tdata),
    .s0_tstrb  (s0_tstrb),
    .s0_tkeep  (s0_tkeep),
    .s0_tlast  (s0_tlast),
    .s0_tuser  (s0_tuser),
    .s0_tready (s0_tready),
    .s1_tvalid (s1_tvalid),
    .s1_tdata  (s1_tdata),
    .s1_tstrb  (s1_tstrb),
    .s1_tkeep  (s1_tkeep),
    .s1_tlast  (s1_tlast),
    .s1_tuser  (s1_tuser),
    .s1_tready (s1_tready),
    .bk_data   (bk_data),
    .bk_tstrb  (bk_tstrb),
    .bk_tkeep  (bk_tkeep),
    .bk_user   (bk_user),
    .bk_tlast  (bk_tlast),
    .bk_valid  (bk_valid),
    .bk_ready  (bk_ready),
    .arb_grant (arb_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic beat_t mk_beat(input int src, input logic [DW-1:0] base, input int i, input int n);
    beat_t b;
    b.data = base + DW'(i);
    b.strb = b.data[KW-1:0];
    b.keep = ~b.data[KW-1:0];
    b.user = UW'(src + 1);
    b.last = (i == n - 1);
    return b;
  endfunction

  task automatic push_pkt(input int src, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) sb.push_back(mk_beat(src, base, i, n));
  endtask

  task automatic drive(input int src, input logic v, input beat_t b);
    if (src == 0) begin
      s0_tvalid = v; s0_tdata = b.data; s0_tstrb = b.strb;
      s0_tkeep = b.keep; s0_tuser = b.user; s0_tlast = b.last;
    end else begin
      s1_tvalid = v; s1_tdata = b.data; s1_tstrb = b.strb;
      s1_tkeep = b.keep; s1_tuser = b.user; s1_tlast = b.last;
    end
  endtask

  function automatic logic rdy(input int src);
    return (src == 0) ? s0_tready : s1_tready;
  endfunction

  // Source driver: holds each beat until a handshake, optionally pausing
  // tvalid for gap_len cycles after beat gap_after while the grant must hold.
  task automatic send(input int src, input int n, input logic [DW-1:0] base,
                      input int gap_after, input int gap_len);
    beat_t b;
    logic  acc;
    int    cnt;
    b = mk_beat(src, base, 0, n);
    for (int i = 0; i < n; i++) begin
      b = mk_beat(src, base, i, n);
      drive(src, 1'b1, b);
      cnt = 0;
      do begin
        @(negedge clk);
        acc = rdy(src);
        @(posedge clk);
        #1;
        cnt++;
      end while (!acc && cnt < 300);
      if (!acc) begin
        check("handshake_timeout", 32'(acc), 32'd1);
        break;
      end
      if (i == gap_after && gap_len > 0) begin
        drive(src, 1'b0, b);
        repeat (gap_len) begin
          @(negedge clk);
          check("gap_grant", 32'(arb_grant), (src == 0) ? 32'd1 : 32'd2);
          check("gap_other_tready", 32'(rdy(1 - src)), 32'd0);
          @(posedge clk);
          #1;
        end
      end
    end
    drive(src, 1'b0, b);
  endtask

  task automatic watch();
    for (int i = 0; i < gpat.size(); i++) begin
      @(negedge clk);
      check("grant_seq", 32'(arb_grant), 32'(gpat[i]));
      if (i < vpat.size()) check("bk_valid_seq", 32'(bk_valid), 32'(vpat[i]));
      @(posedge clk);
    end
  endtask

  task automatic watch_s1_blocked(input int n);
    repeat (n) begin
      @(negedge clk);
      check("s1_tready_prio", 32'(s1_tready), 32'd0);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (sb.size() != 0 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    axi_areset = 1'b1;
    @(posedge clk);
    #1;
    axi_areset = 1'b0;
  endtask

  // Backend monitor: compares consumed beats and checks stalled beats hold.
  initial begin
    beat_t         e;
    logic          hold_pending;
    logic [DW-1:0] hold_data;
    hold_pending = 1'b0;
    hold_data    = '0;
    forever begin
      @(negedge clk);
      if (axi_areset) hold_pending = 1'b0;
      else begin
        if (hold_pending) begin
          check("hold_valid", 32'(bk_valid), 32'd1);
          check("hold_data", bk_data, hold_data);
        end
        if (bk_valid && bk_ready) begin
          if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            check("bk_data", bk_data, e.data);
            check("bk_tlast", 32'(bk_tlast), 32'(e.last));
            check("bk_side", 32'({bk_user, bk_tstrb, bk_tkeep}), 32'({e.user, e.strb, e.keep}));
          end
        end
        hold_pending = bk_valid && !bk_ready;
        hold_data    = bk_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t z;
    z = '0;
    axi_areset = 1'b0;
    prio_mode  = 1'b0;
    bk_ready   = 1'b1;
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    #1 axi_areset = 1'b1;
    #1;
    check("rst_bk_valid", 32'(bk_valid), 32'd0);
    check("rst_grant", 32'(arb_grant), 32'd0);
    check("rst_treadys", 32'({s0_tready, s1_tready}), 32'd0);
    check("rst_bk_data", bk_data, 32'd0);
    check("rst_bk_side", 32'({bk_tstrb, bk_tkeep, bk_user, bk_tlast}), 32'd0);
    @(posedge clk);
    #1 axi_areset = 1'b0;

    // Single 4-beat s0 packet: latency, contiguity, tlast placement.
    push_pkt(0, 4, 32'h11);
    gpat = {2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    vpat = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    @(posedge clk);
    #1;
    fork
      send(0, 4, 32'h11, -1, 0);
      watch();
    join
    drain();

    // Round-robin with both requesters streaming 2-beat packets.
    do_reset();
    push_pkt(0, 2, 32'h300);
    push_pkt(1, 2, 32'h400);
    push_pkt(0, 2, 32'h310);
    push_pkt(1, 2, 32'h410);
    gpat = {2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
            2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    vpat = {};
    @(posedge clk);
    #1;
    fork
      begin send(0, 2, 32'h300, -1, 0); send(0, 2, 32'h310, -1, 0); end
      begin send(1, 2, 32'h400, -1, 0); send(1, 2, 32'h410, -1, 0); end
      watch();
    join
    drain();

    // Fixed priority: s1 starves while s0 keeps requesting.
    do_reset();
    prio_mode = 1'b1;
    push_pkt(0, 2, 32'h500);
    push_pkt(0, 2, 32'h510);
    push_pkt(0, 2, 32'h520);
    push_pkt(1, 2, 32'h600);
    @(posedge clk);
    #1;
    fork
      begin
        send(0, 2, 32'h500, -1, 0);
        send(0, 2, 32'h510, -1, 0);
        send(0, 2, 32'h520, -1, 0);
      end
      send(1, 2, 32'h600, -1, 0);
      watch_s1_blocked(9);
    join
    drain();
    prio_mode = 1'b0;

    // Backend stall in the middle of an s1 packet.
    do_reset();
    push_pkt(1, 3, 32'hA0);
    rpat = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk);
    #1;
    fork
      send(1, 3, 32'hA0, -1, 0);
      begin
        for (int i = 0; i < rpat.size(); i++) begin
          bk_ready = rpat[i];
          @(posedge clk);
          #1;
        end
        bk_ready = 1'b1;
      end
    join
    drain();

    // s0 pauses mid-packet; the grant must not move to the waiting s1.
    do_reset();
    push_pkt(0, 4, 32'h60);
    push_pkt(1, 2, 32'h70);
    @(posedge clk);
    #1;
    fork
      send(0, 4, 32'h60, 1, 5);
      send(1, 2, 32'h70, -1, 0);
    join
    drain();

    // Reset during beat 2 of an s0 packet with a beat held in the backend.
    do_reset();
    drive(0, 1'b1, mk_beat(0, 32'h51, 0, 4));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive(0, 1'b1, mk_beat(0, 32'h51, 1, 4));
    #1 axi_areset = 1'b1;
    #1;
    check("midrst_bk_valid", 32'(bk_valid), 32'd0);
    check("midrst_grant", 32'(arb_grant), 32'd0);
    check("midrst_s0_tready", 32'(s0_tready), 32'd0);
    check("midrst_bk_data", bk_data, 32'd0);
    drive(0, 1'b0, z);
    @(posedge clk);
    #1 axi_areset = 1'b0;
    push_pkt(1, 3, 32'hC0);
    send(1, 3, 32'hC0, -1, 0);
    drain();

    // Mixed packet lengths, including single-beat packets, under random backpressure.
    do_reset();
    push_pkt(0, 1, 32'h800);
    push_pkt(1, 4, 32'h900);
    push_pkt(0, 3, 32'h810);
    push_pkt(1, 1, 32'h910);
    push_pkt(0, 2, 32'h820);
    push_pkt(1, 2, 32'h920);
    stress_done = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        fork
          begin
            send(0, 1, 32'h800, -1, 0);
            send(0, 3, 32'h810, -1, 0);
            send(0, 2, 32'h820, -1, 0);
          end
          begin
            send(1, 4, 32'h900, -1, 0);
            send(1, 1, 32'h910, -1, 0);
            send(1, 2, 32'h920, -1, 0);
          end
        join
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          bk_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        bk_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
